// File: rtl/fdiv_issue_seq.sv
// Issue/sequencing stage in front of the FP32 mantissa divider.
// Operand pairs are queued in a small FIFO. The head pair is driven onto div_a/div_b
// and stays there until its result is captured, because the divider's result and
// flags are combinational on those operands. The FSM issues one start pulse, waits
// for div_valid or a timeout, and holds the captured result on a valid/ready port.

module fdiv_issue_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // Operand input port
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    // Divider interface
    output logic                       div_start,
    output logic [WIDTH-1:0]           div_a,
    output logic [WIDTH-1:0]           div_b,
    input  logic                       div_busy,
    input  logic                       div_valid,
    input  logic [WIDTH-1:0]           div_c,
    input  logic [3:0]                 div_flags,
    // Result port
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_c,
    output logic [4:0]                 out_flags,
    // Status
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StOut
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_mem_q [DEPTH];
    logic [WIDTH-1:0] a_mem_d [DEPTH];
    logic [WIDTH-1:0] b_mem_q [DEPTH];
    logic [WIDTH-1:0] b_mem_d [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    state_e           state_q, state_d;
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic             div_start_q, div_start_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic [4:0]       out_flags_q, out_flags_d;

    logic             push;
    logic             pop;

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign in_ready   = (count_q != CntFull);
    assign push       = in_valid & in_ready;
    assign div_a      = a_mem_q[rd_ptr_q];
    assign div_b      = b_mem_q[rd_ptr_q];
    assign div_start  = div_start_q;
    assign out_valid  = out_valid_q;
    assign out_c      = out_c_q;
    assign out_flags  = out_flags_q;
    assign fifo_count = count_q;

    // FIFO next state: write at wr_ptr, pop only on the capture cycle
    always_comb begin
        a_mem_d  = a_mem_q;
        b_mem_d  = b_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            a_mem_d[wr_ptr_q] = in_a;
            b_mem_d[wr_ptr_q] = in_b;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FSM next state: start pulse, wait with timeout, hold result until consumed
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        div_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        out_flags_d = out_flags_q;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if ((count_q != '0) && !div_busy) begin
                    state_d     = StStart;
                    div_start_d = 1'b1;
                end
            end

            StStart: begin
                tmo_cnt_d = '0;
                state_d   = StWait;
            end

            StWait: begin
                // A real result beats the timeout when both land on the same cycle
                if (div_valid) begin
                    out_c_d     = div_c;
                    out_flags_d = {1'b0, div_flags};
                    out_valid_d = 1'b1;
                    pop         = 1'b1;
                    state_d     = StOut;
                end else if (tmo_cnt_q == TmoLast) begin
                    out_c_d     = '0;
                    out_flags_d = 5'b10000;
                    out_valid_d = 1'b1;
                    pop         = 1'b1;
                    state_d     = StOut;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            StOut: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FIFO storage and pointers; storage is cleared so div_a/div_b are defined after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                a_mem_q[i] <= '0;
                b_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            a_mem_q  <= a_mem_d;
            b_mem_q  <= b_mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FSM state, timeout counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tmo_cnt_q   <= '0;
            div_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            div_start_q <= div_start_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_flags_q <= out_flags_d;
        end
    end

endmodule

// File: tb/tb_fdiv_issue_seq.sv
// Self-checking bench for fdiv_issue_seq with a behavioural divider model
// whose latency and responsiveness are set per test.

module tb_fdiv_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_busy;
    logic        div_valid;
    logic [31:0] div_c;
    logic [3:0]  div_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_c;
    logic [4:0]  out_flags;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;

    // Divider model controls
    int          m_lat = 24;
    bit          m_en  = 1'b1;
    bit          m_chk = 1'b1;
    int          m_cnt = 0;
    logic [31:0] m_a;
    logic [31:0] m_b;

    // Hand-computed single-precision quotients
    logic [31:0] va [5] = '{32'h40C00000, 32'h3F800000, 32'h41200000, 32'h40800000, 32'h42C80000};
    logic [31:0] vb [5] = '{32'h40000000, 32'h40000000, 32'h40A00000, 32'h3F000000, 32'h41200000};
    logic [31:0] vc [5] = '{32'h40400000, 32'h3F000000, 32'h40000000, 32'h41000000, 32'h41200000};

    fdiv_issue_seq #(
        .WIDTH   (32),
        .DEPTH   (4),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_busy   (div_busy),
        .div_valid  (div_valid),
        .div_c      (div_c),
        .div_flags  (div_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c),
        .out_flags  (out_flags),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_start === 1'b1) n_starts++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model result: {flags, quotient}
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) begin
            if (a == 32'h0) return {4'b0010, 32'h7FC00000};
            return {4'b0001, 32'h7F800000};
        end
        for (int i = 0; i < 5; i++) begin
            if (a == va[i] && b == vb[i]) return {4'b0000, vc[i]};
        end
        return 36'h0;
    endfunction

    // Divider model: latches operands on div_start, answers m_lat cycles later
    initial begin
        logic [35:0] r;
        div_busy  = 1'b0;
        div_valid = 1'b0;
        div_c     = '0;
        div_flags = '0;
        forever begin
            @(posedge clk);
            #1;
            div_valid = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    r         = ref_div(m_a, m_b);
                    div_c     = r[31:0];
                    div_flags = r[35:32];
                    div_valid = 1'b1;
                    div_busy  = 1'b0;
                    if (m_chk) begin
                        check_eq("div_a_stable", div_a, m_a);
                        check_eq("div_b_stable", div_b, m_b);
                    end
                end
            end else if (div_start === 1'b1 && m_en) begin
                m_cnt    = m_lat;
                m_a      = div_a;
                m_b      = div_b;
                div_busy = 1'b1;
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (div_start !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("start_seen", div_start, 1);
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq("out_valid_seen", out_valid, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("consumed", out_valid, 0);
    endtask

    initial begin
        int n;
        int s0;
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_div_start", div_start, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_out_c", out_c, 0);
        check_eq("rst_out_flags", out_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic divide 6/2, 24-cycle divider, start latency
        m_lat = 24;
        s0 = n_starts;
        push(32'h40C00000, 32'h40000000);
        check_eq("lat_count1", fifo_count, 1);
        check_eq("lat_no_start", div_start, 0);
        @(posedge clk);
        #1;
        check_eq("lat_start", div_start, 1);
        @(posedge clk);
        #1;
        check_eq("start_one_cycle", div_start, 0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("wait_div_a", div_a, 32'h40C00000);
        check_eq("wait_div_b", div_b, 32'h40000000);
        wait_out(n);
        check_eq("basic_c", out_c, 32'h40400000);
        check_eq("basic_flags", out_flags, 5'b00000);
        check_eq("basic_count", fifo_count, 0);
        check_eq("basic_starts", n_starts - s0, 1);
        consume();

        // Divide by zero and zero by zero
        m_lat = 5;
        push(32'h3F800000, 32'h00000000);
        wait_out(n);
        check_eq("dbz_flags", out_flags, 5'b00001);
        check_eq("dbz_c", out_c, 32'h7F800000);
        consume();
        push(32'h00000000, 32'h00000000);
        wait_out(n);
        check_eq("zbz_flags", out_flags, 5'b00010);
        check_eq("zbz_c", out_c, 32'h7FC00000);
        consume();

        // Five pairs back-to-back with the consumer stalled
        m_lat = 3;
        s0 = n_starts;
        for (int i = 0; i < 4; i++) push(va[i], vb[i]);
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_count", fifo_count, 4);
        check_eq("full_no_out", out_valid, 0);
        push(va[4], vb[4]);
        check_eq("refill_count", fifo_count, 4);
        check_eq("refill_out_valid", out_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("held_starts", n_starts - s0, 1);
        check_eq("held_out_valid", out_valid, 1);
        check_eq("held_out_c", out_c, vc[0]);
        consume();
        for (int i = 1; i < 5; i++) begin
            wait_out(n);
            check_eq("drain_c", out_c, vc[i]);
            check_eq("drain_flags", out_flags, 5'b00000);
            consume();
        end
        check_eq("drain_starts", n_starts - s0, 5);
        check_eq("drain_count", fifo_count, 0);

        // Divider never answers: forced completion 64 cycles after start
        m_en = 1'b0;
        push(va[1], vb[1]);
        push(va[2], vb[2]);
        wait_start();
        wait_out(n);
        check_eq("tmo_cycles", n, 65);
        check_eq("tmo_c", out_c, 0);
        check_eq("tmo_flags", out_flags, 5'b10000);
        check_eq("tmo_count", fifo_count, 1);
        m_en = 1'b1;
        m_lat = 4;
        consume();
        wait_out(n);
        check_eq("after_tmo_c", out_c, vc[2]);
        check_eq("after_tmo_flags", out_flags, 5'b00000);
        consume();

        // div_valid on the same cycle the timeout would fire
        m_lat = 64;
        push(va[3], vb[3]);
        wait_start();
        wait_out(n);
        check_eq("race_cycles", n, 65);
        check_eq("race_c", out_c, vc[3]);
        check_eq("race_flags", out_flags, 5'b00000);
        consume();

        // Reset during WAIT with three entries queued
        m_lat = 30;
        m_chk = 1'b0;
        for (int i = 0; i < 3; i++) push(va[i], vb[i]);
        repeat (8) @(posedge clk);
        #1;
        check_eq("pre_rst_count", fifo_count, 3);
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", fifo_count, 0);
        check_eq("arst_in_ready", in_ready, 1);
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_div_start", div_start, 0);
        check_eq("arst_out_c", out_c, 0);
        check_eq("arst_out_flags", out_flags, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = n_starts;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check_eq("late_valid_ignored", seen, 0);
        check_eq("late_no_start", n_starts - s0, 0);
        check_eq("late_count", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
